// File: rtl/fpu_pkg.sv
// Shared types for the sequential floating-point divider: FSM states,
// operand classes and flag bit positions.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } op_class_e;

    localparam int FLAGS_W       = 5;
    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIV_ZERO  = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

endpackage

// File: rtl/fpu_div_seq_if.sv
// Operand/result handshake bundle between the FPU test datapath and the divider.
interface fpu_div_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [4:0]    flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fpu_class.sv
// Combinational operand classifier; subnormals are treated as zero.
module fpu_class
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_f,
    input  logic [MAN_W-1:0] man_f,
    output op_class_e        cls
);

    always_comb begin
        cls = CLS_NORM;
        if (exp_f == '0) begin
            cls = CLS_ZERO;
        end else if (exp_f == '1) begin
            cls = (man_f == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754-style divider: radix-2 restoring mantissa division,
// round-to-nearest-even, flush-to-zero, valid/ready on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | in_ready high, waiting for an operand pair
//   DIV     | one quotient bit per clock, Q_W clocks
//   NORM    | normalise, round, range-check, register result
//   DONE    | result presented; leaves when consumer takes it
module fpu_div_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_div_seq_if.slave  io
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int Q_W   = MAN_W + 3;
    localparam int R_W   = MAN_W + 2;
    localparam int E_W   = EXP_W + 2;
    localparam int CNT_W = $clog2(Q_W + 1);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam logic [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                sign_q;
    logic [E_W-1:0]      e_q;
    logic [MAN_W:0]      div_q;
    logic [R_W-1:0]      rem_q;
    logic [Q_W-1:0]      quo_q;
    logic [W-1:0]        result_q;
    logic [FLAGS_W-1:0]  flags_q;
    logic                out_valid_q;

    logic                sa, sb, sign_in;
    logic [EXP_W-1:0]    ea, eb;
    logic [MAN_W-1:0]    ma, mb;
    op_class_e           cls_a, cls_b;
    logic                accept, is_special;
    logic [W-1:0]        spec_result;
    logic [FLAGS_W-1:0]  spec_flags;
    logic [E_W-1:0]      e_init;

    assign {sa, ea, ma} = io.a;
    assign {sb, eb, mb} = io.b;
    assign sign_in      = sa ^ sb;
    assign e_init       = E_W'(ea) - E_W'(eb) + E_W'(BIAS);
    assign accept       = (state == ST_IDLE) && io.in_valid;

    fpu_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (.exp_f(ea), .man_f(ma), .cls(cls_a));
    fpu_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (.exp_f(eb), .man_f(mb), .cls(cls_b));

    // Priority matters: NaN beats everything, then the invalid forms.
    always_comb begin
        is_special  = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            spec_result = QNAN;
        end else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
            spec_result              = QNAN;
            spec_flags[FLG_INVALID]  = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_result = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_b == CLS_ZERO) begin
            spec_result              = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags[FLG_DIV_ZERO] = 1'b1;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            spec_result = {sign_in, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    logic                rem_ge;
    logic [R_W-1:0]      rem_diff, rem_next;

    assign rem_ge   = rem_q >= {1'b0, div_q};
    assign rem_diff = rem_q - {1'b0, div_q};
    assign rem_next = (rem_ge ? rem_diff : rem_q) << 1;

    logic                q_msb, guard, sticky, round_up;
    logic [MAN_W-1:0]    man_pre;
    logic [MAN_W:0]      man_rnd;
    logic [E_W-1:0]      e_norm, e_rnd;
    logic [W-1:0]        norm_result;
    logic [FLAGS_W-1:0]  norm_flags;

    assign q_msb    = quo_q[Q_W-1];
    assign man_pre  = q_msb ? quo_q[Q_W-2:2] : quo_q[Q_W-3:1];
    assign guard    = q_msb ? quo_q[1] : quo_q[0];
    assign sticky   = (q_msb & quo_q[0]) | (|rem_q);
    assign e_norm   = q_msb ? e_q : e_q - E_W'(1);
    assign round_up = guard & (sticky | man_pre[0]);
    assign man_rnd  = {1'b0, man_pre} + (MAN_W+1)'(round_up);
    assign e_rnd    = e_norm + E_W'(man_rnd[MAN_W]);

    always_comb begin
        norm_result = {sign_q, e_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
        norm_flags  = '0;
        if (!e_rnd[E_W-1] && e_rnd >= E_MAX) begin
            norm_result               = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_flags[FLG_OVERFLOW]  = 1'b1;
            norm_flags[FLG_INEXACT]   = 1'b1;
        end else if (e_rnd[E_W-1] || e_rnd == '0) begin
            norm_result               = {sign_q, {(W-1){1'b0}}};
            norm_flags[FLG_UNDERFLOW] = 1'b1;
            norm_flags[FLG_INEXACT]   = 1'b1;
        end else begin
            norm_flags[FLG_INEXACT]   = guard | sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (io.in_valid) state_nxt = is_special ? ST_DONE : ST_DIV;
            ST_DIV:  if (cnt == CNT_W'(1)) state_nxt = ST_NORM;
            ST_NORM: state_nxt = ST_DONE;
            ST_DONE: if (out_valid_q && io.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Special results land in DONE one clock before out_valid rises, giving
    // a uniform one-cycle response after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            sign_q      <= 1'b0;
            e_q         <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q <= sign_in;
                        e_q    <= e_init;
                        div_q  <= {1'b1, mb};
                        rem_q  <= {1'b0, 1'b1, ma};
                        quo_q  <= '0;
                        if (is_special) begin
                            cnt      <= '0;
                            result_q <= spec_result;
                            flags_q  <= spec_flags;
                        end else begin
                            cnt      <= CNT_W'(Q_W);
                        end
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[Q_W-2:0], rem_ge};
                    cnt   <= cnt - CNT_W'(1);
                end
                ST_NORM: begin
                    result_q    <= norm_result;
                    flags_q     <= norm_flags;
                    out_valid_q <= 1'b1;
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == ST_IDLE);
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.flags     = flags_q;

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed + randomized bench for fpu_div_seq against an exact-remainder
// single-precision reference model.
module tb_fpu_div_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fpu_div_seq_if #(.EXP_W(8), .MAN_W(23)) io ();

    fpu_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact model: quotient mantissa by integer division, RNE from the true remainder.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [4:0] f, output bit special);
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic        s, az, bz, ai, bi, an, bn;
        longint unsigned n1, d1, q, rm;
        int          e;
        bit          up;
        ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
        s  = a[31] ^ b[31];
        az = (ea == 8'd0);  bz = (eb == 8'd0);
        ai = (ea == 8'hFF) && (ma == 23'd0); bi = (eb == 8'hFF) && (mb == 23'd0);
        an = (ea == 8'hFF) && (ma != 23'd0); bn = (eb == 8'hFF) && (mb != 23'd0);
        f = 5'b0; special = 1'b1; r = 32'h0;
        if (an || bn)                        r = 32'h7FC00000;
        else if ((az && bz) || (ai && bi)) begin r = 32'h7FC00000; f = 5'b10000; end
        else if (ai)                         r = {s, 8'hFF, 23'd0};
        else if (bz)                     begin r = {s, 8'hFF, 23'd0}; f = 5'b01000; end
        else if (az || bi)                   r = {s, 31'd0};
        else begin
            special = 1'b0;
            n1 = longint'({1'b1, ma});
            d1 = longint'({1'b1, mb});
            e  = int'(ea) - int'(eb) + 127;
            if (n1 < d1) begin n1 = n1 << 24; e = e - 1; end
            else               n1 = n1 << 23;
            q  = n1 / d1;
            rm = n1 % d1;
            up = (2 * rm > d1) || ((2 * rm == d1) && q[0]);
            q  = q + longint'(up);
            if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
            if (e >= 255)     begin r = {s, 8'hFF, 23'd0}; f = 5'b00101; end
            else if (e <= 0)  begin r = {s, 31'd0};        f = 5'b00011; end
            else begin
                r = {s, 8'(e), q[22:0]};
                f = {4'b0, (rm != 0)};
            end
        end
    endtask

    task automatic start_op(input logic [31:0] op_a, input logic [31:0] op_b);
        int w = 0;
        while (io.in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        io.in_valid = 1'b1;
        io.a = op_a;
        io.b = op_b;
        @(negedge clk);
        io.in_valid = 1'b0;
        io.a = $urandom();
        io.b = $urandom();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (io.out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic drain(input string tag);
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        chk({tag, " valid_drop"}, 64'(io.out_valid), 64'd0);
        chk({tag, " ready_back"}, 64'(io.in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] er, input logic [4:0] ef,
                          input int elat, input string tag);
        int n;
        start_op(op_a, op_b);
        wait_valid(n);
        chk({tag, " latency"}, 64'(n), 64'(elat));
        chk({tag, " result"},  64'(io.result), 64'(er));
        chk({tag, " flags"},   64'(io.flags), 64'(ef));
        drain(tag);
    endtask

    function automatic logic [31:0] rnd_op(input int mode);
        logic [31:0] v;
        case (mode)
            0: v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom())};
            1: v = $urandom();
            default: v = {1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 10))
                                                      : 8'($urandom_range(245, 254)),
                          23'($urandom())};
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rb, er;
        logic [4:0]  ef;
        bit          sp;
        int          n;
        bit          any_valid;
        logic [31:0] pool [4];
        pool[0] = 32'h00000000; pool[1] = 32'h80000000;
        pool[2] = 32'h7F800000; pool[3] = 32'h7FC00001;

        io.in_valid = 1'b0; io.a = '0; io.b = '0; io.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready",  64'(io.in_ready),  64'd1);
        chk("rst out_valid", 64'(io.out_valid), 64'd0);
        chk("rst result",    64'(io.result),    64'd0);
        chk("rst flags",     64'(io.flags),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, "6/2");
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27, "1/3");
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1,  "1/0");
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1,  "0/0");
        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 27, "ovf");
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 27, "unf");
        run_op(32'hFF800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1,  "inf/inf");
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1,  "inf/2");
        run_op(32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 1,  "-2/inf");
        run_op(32'h3F800000, 32'h7F800001, 32'h7FC00000, 5'b00000, 1,  "1/nan");
        run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 27, "-6/2");

        // Back-pressure: result held, no accept while busy, accept only after drop.
        start_op(32'h40C00000, 32'h40000000);
        wait_valid(n);
        chk("bp latency", 64'(n), 64'd27);
        io.in_valid = 1'b1; io.a = 32'h3F800000; io.b = 32'h40400000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold result", 64'(io.result),    64'h40400000);
            chk("bp hold valid",  64'(io.out_valid), 64'd1);
            chk("bp in_ready",    64'(io.in_ready),  64'd0);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        chk("bp drop valid", 64'(io.out_valid), 64'd0);
        chk("bp no accept on drop edge", 64'(io.in_ready), 64'd1);
        @(negedge clk);
        io.in_valid = 1'b0;
        chk("bp second accepted", 64'(io.in_ready), 64'd0);
        wait_valid(n);
        chk("bp2 latency", 64'(n), 64'd27);
        chk("bp2 result",  64'(io.result), 64'h3EAAAAAB);
        chk("bp2 flags",   64'(io.flags),  64'd1);
        drain("bp2");

        // Reset in the middle of a divide.
        start_op(32'h3F800000, 32'h40400000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(io.out_valid), 64'd0);
        chk("midrst in_ready",  64'(io.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (io.out_valid === 1'b1) any_valid = 1'b1;
        end
        chk("midrst no result",   64'(any_valid),   64'd0);
        chk("midrst idle",        64'(io.in_ready), 64'd1);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, "post-rst 6/2");

        for (int i = 0; i < 40; i++) begin
            ra = rnd_op(i % 3);
            rb = rnd_op((i / 3) % 3);
            if (i % 7 == 0) rb[22:0] = ra[22:0];
            if (i % 5 == 0) rb = pool[$urandom_range(0, 3)];
            if (i % 11 == 0) ra = pool[$urandom_range(0, 3)];
            model(ra, rb, er, ef, sp);
            run_op(ra, rb, er, ef, sp ? 1 : 27, $sformatf("rnd%0d %h/%h", i, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_div_seq.md
# fpu_div_seq

Parametrised, sequential IEEE-754-style floating-point divider; successor to the team's single-cycle single-precision divider. Adds configurable exponent and mantissa widths, a radix-2 restoring mantissa divider (one quotient bit per clock), round-to-nearest-even, special-case handling and exception flags. Sits in the FPU test datapath behind a valid/ready handshake on both sides, so it accepts one operation at a time and can be back-pressured by the result consumer.

## Interface
- EXP_W, 8: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa width, excluding the hidden bit.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  divider idle, able to accept.
- a  in  1+EXP_W+MAN_W  dividend {sign, exp, man}.
- b  in  1+EXP_W+MAN_W  divisor.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+MAN_W  quotient.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

## Operation
- Accept when in_valid && in_ready; a and b are registered, and later changes on a/b are ignored.
- Classify each operand: zero (exp==0, any man: subnormals are flushed to zero), inf (exp all-ones, man==0), NaN (exp all-ones, man!=0), normal.
- Sign = sa ^ sb for every non-NaN result.
- Special cases bypass DIV and go straight to DONE:
  - any NaN input -> canonical qNaN {0, all-ones, 1 then zeros}; no flag.
  - 0/0 or inf/inf -> qNaN, invalid.
  - finite nonzero / 0 -> signed inf, div_by_zero.
  - inf/finite -> signed inf.
  - 0/nonzero or finite/inf -> signed zero.
  - No flags set unless listed above.
- Normal path:
  - Q_W = MAN_W+3 quotient bits by restoring division of {1,ma} by {1,mb}, one bit per DIV cycle. Remainder width MAN_W+2.
  - Exponent: signed EXP_W+2-bit, e = ea - eb + BIAS.
  - NORM: if quotient MSB == 0, shift left 1 and e -= 1. Take guard bit; sticky = OR of remaining bits and nonzero remainder.
  - Round to nearest even; if the mantissa carries out, e += 1.
  - After rounding, e >= 2^EXP_W-1 -> signed inf, overflow|inexact.
  - e <= 0 -> signed zero, underflow|inexact (flush to zero).
  - Otherwise inexact = guard|sticky.
- FSM: IDLE -> (accept) DIV or DONE(special); DIV -> NORM after Q_W iterations; NORM -> DONE; DONE -> IDLE when out_ready.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, flags=0, iteration counter 0.
- in_ready = (state==IDLE). No new operation is accepted while busy, including the cycle out_valid drops.
- Normal latency: accept edge T0; DIV occupies edges T1..T(Q_W); NORM at edge T(Q_W+1) registers result. out_valid is high from T(Q_W+1), i.e. 27 cycles for defaults.
- Special latency: out_valid high from the edge after the accept edge.
- result and flags are held stable while out_valid && !out_ready. out_valid falls on the edge where out_ready is sampled high. in_ready rises on that same edge. No combinational path from out_ready to in_ready.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is emitted.

## Structure
- Package fpu_pkg: FSM state enum (IDLE, DIV, NORM, DONE), flag bit indices, operand-class enum (ZERO, NORM, INF, NAN).
- Sub-module fpu_class: combinational operand classifier, parametrised on EXP_W/MAN_W, instantiated for a and b.
- Iteration counter width: clog2(Q_W+1).

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, flags 0, out_valid at cycle 27.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, inexact only.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero. 0x00000000/0x00000000 -> 0x7FC00000, invalid. Both respond 1 cycle after accept.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow|inexact. 0x00800000 / 0x40000000 -> 0x00000000, underflow|inexact.
- Hold out_ready=0 for 10 cycles: result stable, in_ready=0, second in_valid is not accepted. Then release: next op is accepted only after out_valid falls.
- Assert rst_n=0 at iteration 10 of a divide: out_valid stays 0 and in_ready=1 after release. Run a fresh 6/2 and check it is correct.
